// File: rtl/modp40_pkg.sv
// Shared constants and state encoding for the carry-save to binary mod-p output stage.
// The modulus must satisfy 2^(W+1) < 4P so that three subtractions always suffice.
package modp40_pkg;

  localparam int          W       = 40;
  localparam logic [W-1:0] P      = 40'h85bfc65fef;
  localparam int          CHUNK_W = 10;
  localparam int          NCHUNK  = W / CHUNK_W;
  localparam int          IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int          MAX_SUB = 3;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    REDUCE,
    DONE
  } state_e;

endpackage : modp40_pkg

// File: rtl/cpa_chunk.sv
// One CHUNK_W-bit slice of the carry-propagate adder; the top reuses it once per chunk.
module cpa_chunk
  import modp40_pkg::*;
(
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               cin_i,
  output logic [CHUNK_W-1:0] sum_o,
  output logic               cout_o
);

  logic [CHUNK_W:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK_W{1'b0}}, cin_i};
  assign sum_o    = full_sum[CHUNK_W-1:0];
  assign cout_o   = full_sum[CHUNK_W];

endmodule : cpa_chunk

// File: rtl/cs2bin_modp_40.sv
// Carry-save pair (c,s) -> canonical residue (c+s) mod P: chunked multi-cycle add,
// then repeated conditional subtraction of P, with valid/ready on both sides.
module cs2bin_modp_40
  import modp40_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_c,
  input  logic [W-1:0] in_s,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic         busy
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W:0]         acc_q, acc_d;
  logic [W-1:0]       c_q, c_d;
  logic [W-1:0]       s_q, s_d;
  logic [W-1:0]       out_r_q, out_r_d;
  logic [1:0]         sub_cnt_q, sub_cnt_d;

  logic [CHUNK_W-1:0] chunk_sum;
  logic               chunk_cout;
  logic [W+1:0]       diff;
  logic               ge_p;

  cpa_chunk u_cpa (
    .a_i    (c_q[idx_q*CHUNK_W +: CHUNK_W]),
    .b_i    (s_q[idx_q*CHUNK_W +: CHUNK_W]),
    .cin_i  (carry_q),
    .sum_o  (chunk_sum),
    .cout_o (chunk_cout)
  );

  // The borrow out of acc - P doubles as the acc >= P comparison.
  assign diff = {1'b0, acc_q} - {2'b00, P};
  assign ge_p = ~diff[W+1];

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    acc_d     = acc_q;
    c_d       = c_q;
    s_d       = s_q;
    out_r_d   = out_r_q;
    sub_cnt_d = sub_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          c_d       = in_c;
          s_d       = in_s;
          acc_d     = '0;
          carry_d   = 1'b0;
          idx_d     = '0;
          sub_cnt_d = '0;
          state_d   = ADD;
        end
      end
      ADD: begin
        acc_d[idx_q*CHUNK_W +: CHUNK_W] = chunk_sum;
        carry_d                         = chunk_cout;
        if (idx_q == IDX_W'(NCHUNK - 1)) begin
          acc_d[W] = chunk_cout;
          idx_d    = '0;
          state_d  = REDUCE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      REDUCE: begin
        if (ge_p) begin
          acc_d     = diff[W:0];
          sub_cnt_d = sub_cnt_q + 2'd1;
        end else begin
          out_r_d = acc_q[W-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the operand and accumulator registers are reset as well, so a dropped
  // operation leaves nothing behind that could surface as a stale result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      acc_q     <= '0;
      c_q       <= '0;
      s_q       <= '0;
      out_r_q   <= '0;
      sub_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      acc_q     <= acc_d;
      c_q       <= c_d;
      s_q       <= s_d;
      out_r_q   <= out_r_d;
      sub_cnt_q <= sub_cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_r     = out_r_q;

  a_max_sub: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == REDUCE && ge_p) |-> (sub_cnt_q < 2'(MAX_SUB)));

  a_canonical: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> (out_r_q < P));

endmodule : cs2bin_modp_40

// File: tb/tb_cs2bin_modp_40.sv
// Directed and randomized checks of cs2bin_modp_40 against an arithmetic model:
// residue = (c+s) % P, subtractions k = (c+s) / P, latency = NCHUNK + k + 1.
module tb_cs2bin_modp_40;

  localparam longint unsigned PM     = 64'h85bfc65fef;
  localparam longint unsigned MAX40  = 64'hFF_FFFF_FFFF;
  localparam int              NCH    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_c;
  logic [39:0] in_s;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_r;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  cs2bin_modp_40 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .in_s      (in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input longint unsigned obs, input longint unsigned exp, input string tag);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [39:0] c, input logic [39:0] s, output int waited);
    @(negedge clk);
    in_c     = c;
    in_s     = s;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk(64'(in_ready), 1, "in_ready_before_accept");
    @(posedge clk);
    #1;
    chk(64'(busy), 1, "busy_after_accept");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for the result of (c,s), stalls the consumer, optionally holds the next
  // request on the input during the stall, then completes the output handshake.
  task automatic get_result(input logic [39:0] c, input logic [39:0] s, input int stall,
                            input bit hold_next, input logic [39:0] nc, input logic [39:0] ns);
    longint unsigned sum;
    longint unsigned exp_r;
    int              exp_k;
    int              lat;
    sum   = longint'(c) + longint'(s);
    exp_r = sum % PM;
    exp_k = int'(sum / PM);
    lat   = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    chk(64'(lat), 64'(NCH + exp_k + 1), "latency");
    chk(64'(out_r), exp_r, "out_r");
    chk(64'(in_ready), 0, "in_ready_in_done");
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (hold_next) begin
        in_c     = nc;
        in_s     = ns;
        in_valid = 1'b1;
      end
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk(64'(out_valid), 1, "stall_out_valid");
      chk(64'(out_r), exp_r, "stall_out_r");
      chk(64'(in_ready), 0, "stall_in_ready");
    end
    @(negedge clk);
    if (hold_next) begin
      in_c     = nc;
      in_s     = ns;
      in_valid = 1'b1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk(64'(out_valid), 0, "out_valid_after_handshake");
    chk(64'(in_ready), 1, "in_ready_after_handshake");
  endtask

  task automatic run(input logic [39:0] c, input logic [39:0] s, input int stall);
    int w;
    send(c, s, w);
    get_result(c, s, stall, 1'b0, '0, '0);
  endtask

  initial begin
    int              w;
    int              stale;
    longint unsigned c_l;
    longint unsigned s_l;
    longint unsigned tgt;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_c      = '0;
    in_s      = '0;
    out_ready = 1'b0;

    #1;
    chk(64'(out_valid), 0, "reset_out_valid");
    chk(64'(out_r), 0, "reset_out_r");
    chk(64'(busy), 0, "reset_busy");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk(64'(in_ready), 1, "in_ready_after_release");

    // Directed corner cases: zero, exactly P, maximal sum, P-1.
    run(40'h0, 40'h0, 0);
    run(40'h85bfc65fef, 40'h0, 0);
    run(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 0);
    chk(64'(out_r), 64'h6EC0ACE031, "max_sum_residue");
    run(40'h85bfc65fee, 40'h0, 0);

    // Backpressure with the next request held on the input during the stall.
    send(40'h12_3456_789A, 40'hFE_DCBA_9876, w);
    get_result(40'h12_3456_789A, 40'hFE_DCBA_9876, 3, 1'b1, 40'hAB_CDEF_0123, 40'h55_5555_5555);
    send(40'hAB_CDEF_0123, 40'h55_5555_5555, w);
    chk(64'(w), 0, "accept_next_cycle");
    get_result(40'hAB_CDEF_0123, 40'h55_5555_5555, 0, 1'b0, '0, '0);

    // Randomized: fully random pairs and sums straddling multiples of P.
    for (int n = 0; n < 24; n++) begin
      c_l = longint'({8'($urandom), 32'($urandom)});
      s_l = longint'({8'($urandom), 32'($urandom)});
      if (n % 2 == 1) begin
        tgt = longint'($urandom_range(1, 3)) * PM + longint'($urandom_range(0, 2)) - 1;
        if (tgt > 2 * MAX40) tgt = 2 * MAX40;
        if (tgt > c_l && tgt - c_l > MAX40) c_l = tgt - MAX40;
        if (c_l > tgt) c_l = tgt;
        s_l = tgt - c_l;
      end
      run(40'(c_l), 40'(s_l), int'($urandom_range(0, 2)));
    end

    // Reset in the second ADD cycle after a nonzero result is still held in out_r.
    run(40'h00_0000_1234, 40'h00_0000_0001, 0);
    send(40'h77_7777_7777, 40'h88_8888_8888, w);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk(64'(out_valid), 0, "midop_reset_out_valid");
    chk(64'(out_r), 0, "midop_reset_out_r");
    chk(64'(busy), 0, "midop_reset_busy");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk(64'(in_ready), 1, "midop_reset_in_ready");
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) stale++;
    end
    chk(64'(stale), 0, "no_stale_result");
    run(40'h01_0000_0000, 40'h02_0000_0000, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cs2bin_modp_40
